posit_unpack_stream: RTL and testbench

- Streaming posit decoder: accepts packed posit words (the format `positaccum_8` emits on `result`) and unpacks each into `value_accum` fields (sign, scale, fraction, inf, zero).
- Sits downstream of the accumulator, or in front of any consumer that needs decoded operands, for example result checking or re-injection into a scale-domain datapath.
- Pipelined decoder with valid/ready handshake on both sides and an output FIFO; backpressure is credit-based, so `in_ready` never depends combinationally on `out_ready`.

---
 rtl/posit_defines.sv | 37 +++
 rtl/posit_unpack_fifo.sv | 58 +++++
 rtl/posit_unpack_stream.sv | 160 ++++++++++++++++
 tb/tb_posit_unpack_stream.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_defines.sv
// Shared types and constants for the streaming posit decoder.
package posit_defines;

    localparam int NBITS        = 32;
    localparam int ES           = 2;
    localparam int FBITS_UNPACK = NBITS - 3 - ES;
    localparam int SCALEW       = 8;
    localparam int RUNW         = $clog2(NBITS) + 1;

    // Decoded posit: fraction excludes the hidden bit and is MSB-aligned.
    typedef struct packed {
        logic                     sign;
        logic signed [SCALEW-1:0] scale;
        logic [FBITS_UNPACK-1:0]  fraction;
        logic                     inf;
        logic                     zero;
    } value_accum;

    localparam value_accum VALUE_ZERO = '{sign: 1'b0, scale: '0, fraction: '0, inf: 1'b0, zero: 1'b1};

    // Length of the run of identical bits starting at the MSB of the body.
    function automatic logic [RUNW-1:0] regime_run(input logic [NBITS-2:0] body);
        logic [RUNW-1:0] run;
        logic            stop;
        run  = '0;
        stop = 1'b0;
        for (int i = NBITS - 2; i >= 0; i--) begin
            if (!stop && (body[i] == body[NBITS-2])) begin
                run = run + RUNW'(1);
            end else begin
                stop = 1'b1;
            end
        end
        return run;
    endfunction

endpackage

// File: rtl/posit_unpack_fifo.sv
// First-word-fall-through FIFO holding decoded words until the consumer takes them.
module posit_unpack_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_do_wr = i_wr && !o_full;
    assign w_do_rd = i_rd && !o_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_wr && !w_do_rd)      r_count <= r_count + CW'(1);
            else if (!w_do_wr && w_do_rd) r_count <= r_count - CW'(1);
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(i_wr && o_full));

endmodule

// File: rtl/posit_unpack_stream.sv
// Streaming posit decoder: 3-stage decode pipeline, output FIFO, credit-based input flow control.
module posit_unpack_stream
    import posit_defines::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output value_accum       out_value,
    output logic [NBITS-1:0] out_raw,
    output logic             busy
);
    localparam int CREDW = $clog2(FIFO_DEPTH + 1);
    localparam int TAILW = ES + FBITS_UNPACK;
    localparam int FW    = $bits(value_accum) + NBITS;

    logic             w_accept, w_emit;
    logic             r_in_ready;
    logic [CREDW-1:0] r_credit, w_credit_next;

    logic             r_s0_valid, r_s0_sign, r_s0_zero, r_s0_inf;
    logic [NBITS-1:0] r_s0_raw;
    logic [NBITS-2:0] r_s0_body, w_neg_body;
    logic [RUNW-1:0]  w_s0_run;
    logic signed [SCALEW-1:0] w_s0_k;

    logic             r_s1_valid, r_s1_sign, r_s1_zero, r_s1_inf;
    logic [NBITS-1:0] r_s1_raw;
    logic [TAILW-1:0] r_s1_tail, w_s1_shifted;
    logic [RUNW-1:0]  r_s1_run;
    logic signed [SCALEW-1:0] r_s1_k;
    value_accum       w_s2_value;

    logic             r_s2_valid;
    value_accum       r_s2_value;
    logic [NBITS-1:0] r_s2_raw;

    logic [FW-1:0]    w_fifo_rdata;
    logic             w_fifo_full, w_fifo_empty;
    logic [CREDW-1:0] w_fifo_count;
    value_accum       w_rd_value;
    logic [NBITS-1:0] w_rd_raw;

    assign in_ready  = r_in_ready;
    assign out_valid = !w_fifo_empty;
    assign busy      = (r_credit != '0);
    assign w_accept  = in_valid && r_in_ready;
    assign w_emit    = out_valid && out_ready;

    // Credits count words accepted but not yet emitted.
    always_comb begin
        w_credit_next = r_credit;
        if (w_accept && !w_emit)      w_credit_next = r_credit + CREDW'(1);
        else if (!w_accept && w_emit) w_credit_next = r_credit - CREDW'(1);
    end

    // Credit register and registered ready, so in_ready never sees out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credit   <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_credit   <= w_credit_next;
            r_in_ready <= (w_credit_next < CREDW'(FIFO_DEPTH));
        end
    end

    // Pipeline valid bits; the pipeline never stalls because credits bound occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s0_valid <= w_accept;
            r_s1_valid <= r_s0_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    assign w_neg_body = '0 - in_data[NBITS-2:0];

    // S0: capture accepted word, take magnitude of the body, flag zero/inf.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s0_raw  <= in_data;
            r_s0_sign <= in_data[NBITS-1];
            r_s0_body <= in_data[NBITS-1] ? w_neg_body : in_data[NBITS-2:0];
            r_s0_zero <= (in_data == '0);
            r_s0_inf  <= in_data[NBITS-1] && (in_data[NBITS-2:0] == '0);
        end
    end

    assign w_s0_run = regime_run(r_s0_body);
    assign w_s0_k   = r_s0_body[NBITS-2] ? (SCALEW'(w_s0_run) - SCALEW'(1))
                                         : (SCALEW'(0) - SCALEW'(w_s0_run));

    // S1: regime run length and k; keep only the bits below the shortest regime+terminator.
    always_ff @(posedge clk) begin
        r_s1_raw  <= r_s0_raw;
        r_s1_sign <= r_s0_sign;
        r_s1_zero <= r_s0_zero;
        r_s1_inf  <= r_s0_inf;
        r_s1_tail <= r_s0_body[TAILW-1:0];
        r_s1_run  <= w_s0_run;
        r_s1_k    <= w_s0_k;
    end

    // A run of 1 leaves the tail aligned already; each extra regime bit shifts one more, zero-filling.
    assign w_s1_shifted = r_s1_tail << (r_s1_run - RUNW'(1));

    // Assemble the decoded value; zero and inf carry no sign, scale or fraction.
    always_comb begin
        w_s2_value = '0;
        if (r_s1_zero) begin
            w_s2_value.zero = 1'b1;
        end else if (r_s1_inf) begin
            w_s2_value.inf = 1'b1;
        end else begin
            w_s2_value.sign     = r_s1_sign;
            w_s2_value.scale    = (r_s1_k <<< ES)
                                + $signed({{(SCALEW-ES){1'b0}}, w_s1_shifted[TAILW-1 -: ES]});
            w_s2_value.fraction = w_s1_shifted[FBITS_UNPACK-1:0];
        end
    end

    // S2: register the decoded word for the FIFO write on the next edge.
    always_ff @(posedge clk) begin
        r_s2_value <= w_s2_value;
        r_s2_raw   <= r_s1_raw;
    end

    posit_unpack_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (r_s2_valid),
        .i_wdata ({r_s2_value, r_s2_raw}),
        .i_rd    (out_ready),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign {w_rd_value, w_rd_raw} = w_fifo_rdata;
    assign out_value = w_fifo_empty ? VALUE_ZERO : w_rd_value;
    assign out_raw   = w_fifo_empty ? '0 : w_rd_raw;

    a_credit_covers_fifo: assert property (@(posedge clk) disable iff (!rst)
        (w_fifo_count <= r_credit) && (!w_fifo_full || (r_credit == CREDW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_posit_unpack_stream.sv
// Directed and scoreboarded checks for the streaming posit decoder.
module tb_posit_unpack_stream;
    import posit_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    value_accum  out_value;
    logic [31:0] out_raw;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n_emit = 0;
    int max_inflight = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0]       word;
        logic              sign;
        logic signed [7:0] scale;
        logic [26:0]       frac;
        logic              inf;
        logic              zero;
    } vec_t;

    vec_t vecs[11];

    posit_unpack_stream #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_raw   (out_raw),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Bit-serial reference decode.
    function automatic value_accum model(input logic [31:0] w);
        value_accum v;
        logic [30:0] a;
        int i, run, k, e;
        v = '0;
        if (w == 32'h0) begin
            v.zero = 1'b1;
            return v;
        end
        if (w == 32'h80000000) begin
            v.inf = 1'b1;
            return v;
        end
        v.sign = w[31];
        a = w[31] ? 31'(-w) : w[30:0];
        i = 30;
        run = 0;
        while (i >= 0 && a[i] == a[30]) begin
            run++;
            i--;
        end
        k = a[30] ? run - 1 : -run;
        i--;
        e = 0;
        for (int b = 0; b < 2; b++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        for (int b = 26; b >= 0; b--) begin
            v.fraction[b] = (i >= 0) ? a[i] : 1'b0;
            i--;
        end
        v.scale = 8'(k * 4 + e);
        return v;
    endfunction

    // One clock: record handshakes seen before the edge, then sample #1 after it.
    task automatic step();
        logic        acc, emt;
        logic [31:0] exp_raw;
        acc = in_valid && in_ready;
        emt = out_valid && out_ready;
        if (rst && emt) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 64'(out_raw), 64'hdead);
            end else begin
                exp_raw = sb.pop_front();
                check("sb_raw", 64'(out_raw), 64'(exp_raw));
                check("sb_value", 64'(out_value), 64'(model(exp_raw)));
            end
            n_emit++;
        end
        if (rst && acc) begin
            sb.push_back(in_data);
            n_acc++;
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            sb.delete();
            n_acc  = 0;
            n_emit = 0;
        end
        if (n_acc - n_emit > max_inflight) max_inflight = n_acc - n_emit;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        value_accum  zv;
        logic [31:0] seq[10];
        int lat, g, base_acc, base_emit, cyc;

        vecs[0]  = '{32'h40000000, 1'b0, 8'sd0,    27'h0,       1'b0, 1'b0};
        vecs[1]  = '{32'h48000000, 1'b0, 8'sd1,    27'h0,       1'b0, 1'b0};
        vecs[2]  = '{32'h44000000, 1'b0, 8'sd0,    27'h4000000, 1'b0, 1'b0};
        vecs[3]  = '{32'hC0000000, 1'b1, 8'sd0,    27'h0,       1'b0, 1'b0};
        vecs[4]  = '{32'h00000000, 1'b0, 8'sd0,    27'h0,       1'b0, 1'b1};
        vecs[5]  = '{32'h80000000, 1'b0, 8'sd0,    27'h0,       1'b1, 1'b0};
        vecs[6]  = '{32'h7FFFFFFF, 1'b0, 8'sd120,  27'h0,       1'b0, 1'b0};
        vecs[7]  = '{32'h00000001, 1'b0, -8'sd120, 27'h0,       1'b0, 1'b0};
        vecs[8]  = '{32'h3FFFFFFF, 1'b0, -8'sd1,   27'h7FFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'h60000000, 1'b0, 8'sd4,    27'h0,       1'b0, 1'b0};
        vecs[10] = '{32'hBFFFFFFF, 1'b1, 8'sd0,    27'h1,       1'b0, 1'b0};

        // Reset state
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) step();
        zv = '0;
        zv.zero = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_value", 64'(out_value), 64'(zv));
        rst = 1'b1;
        step();
        check("rst_release_in_ready", 64'(in_ready), 64'd1);

        // Single words from the table, out_ready held high
        out_ready = 1'b1;
        for (int v = 0; v < 11; v++) begin
            in_valid = 1'b1;
            in_data = vecs[v].word;
            g = 0;
            while (!in_ready && g < 20) begin
                step();
                g++;
            end
            check("vec_ready", 64'(in_ready), 64'd1);
            step();
            in_valid = 1'b0;
            in_data = 'x;
            lat = 1;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check("vec_latency", 64'(lat), 64'd4);
            check("vec_raw", 64'(out_raw), 64'(vecs[v].word));
            check("vec_sign", 64'(out_value.sign), 64'(vecs[v].sign));
            check("vec_scale", 64'(out_value.scale), 64'(vecs[v].scale));
            check("vec_frac", 64'(out_value.fraction), 64'(vecs[v].frac));
            check("vec_inf", 64'(out_value.inf), 64'(vecs[v].inf));
            check("vec_zero", 64'(out_value.zero), 64'(vecs[v].zero));
            step();
        end
        in_data = '0;

        // Backpressure: 10 words offered with out_ready low
        for (int i = 0; i < 10; i++) seq[i] = vecs[i].word ^ 32'(i);
        out_ready = 1'b0;
        base_acc = n_acc;
        base_emit = n_emit;
        for (int c = 0; c < 20; c++) begin
            in_valid = (n_acc - base_acc) < 10;
            in_data = seq[(n_acc - base_acc) % 10];
            step();
        end
        check("bp_accepted", 64'(n_acc - base_acc), 64'd4);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 3; c++) begin
            check("bp_hold_raw", 64'(out_raw), 64'(seq[0]));
            check("bp_hold_value", 64'(out_value), 64'(model(seq[0])));
            step();
        end
        out_ready = 1'b1;
        g = 0;
        while ((n_emit - base_emit) < 10 && g < 200) begin
            in_valid = (n_acc - base_acc) < 10;
            in_data = seq[(n_acc - base_acc) % 10];
            step();
            g++;
        end
        in_valid = 1'b0;
        check("bp_drained", 64'(n_emit - base_emit), 64'd10);
        check("bp_busy_idle", 64'(busy), 64'd0);

        // Throughput: continuous input and output for 100 words
        max_inflight = 0;
        base_acc = n_acc;
        base_emit = n_emit;
        cyc = 0;
        while ((n_emit - base_emit) < 100 && cyc < 400) begin
            in_valid = (n_acc - base_acc) < 100;
            in_data = $urandom;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("tp_emitted", 64'(n_emit - base_emit), 64'd100);
        check("tp_credit_peak", 64'(max_inflight), 64'd4);
        check("tp_cycles_bounded", 64'(cyc <= 135), 64'd1);

        // Random traffic with 50% out_ready
        max_inflight = 0;
        base_acc = n_acc;
        base_emit = n_emit;
        cyc = 0;
        while ((n_acc - base_acc) < 1000 && cyc < 20000) begin
            in_valid = $urandom_range(0, 9) < 7;
            case ($urandom_range(0, 15))
                0:       in_data = 32'h0;
                1:       in_data = 32'h80000000;
                2:       in_data = 32'h7FFFFFFF;
                3:       in_data = 32'h80000001;
                4:       in_data = 32'(1) << $urandom_range(0, 31);
                default: in_data = $urandom;
            endcase
            out_ready = $urandom_range(0, 1) == 1;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        g = 0;
        while (sb.size() > 0 && g < 50) begin
            step();
            g++;
        end
        check("rnd_accepted", 64'(n_acc - base_acc), 64'd1000);
        check("rnd_emitted", 64'(n_emit - base_emit), 64'd1000);
        check("rnd_credit_bound", 64'(max_inflight <= 4), 64'd1);

        // Reset with 3 words in flight
        out_ready = 1'b0;
        base_acc = n_acc;
        g = 0;
        in_valid = 1'b1;
        while ((n_acc - base_acc) < 3 && g < 20) begin
            in_data = 32'h40000000 + 32'(n_acc - base_acc);
            step();
            g++;
        end
        in_valid = 1'b0;
        step();
        check("mid_pre_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        step();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        step();
        check("mid_release_in_ready", 64'(in_ready), 64'd1);
        check("mid_release_busy", 64'(busy), 64'd0);
        out_ready = 1'b1;
        base_emit = n_emit;
        g = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) g++;
            step();
        end
        check("mid_no_output", 64'(g), 64'd0);
        check("mid_no_emit", 64'(n_emit - base_emit), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
